id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised ID->EX pipeline register with valid/ready handshake, stall and flush.
//  Sits between decode (regfile read, inst decode) and execute. Back-pressure from EX
//  (load-use stall, multi-cycle ALU) holds the stage. Branch/exception flush turns it into a bubble.
//  Cycle counter of EX back-pressure for perf analysis.
// PARAMETERS
//  DATA_W  32  width of fourPC, readData1, readData2, instruction
//  NAME_W  8   width of inst_name (decoded instruction code; 0 = NOP)
//  REG_W   5   width of register_d (destination register index)
//  CNT_W   16  width of stall_cnt
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low
//  flush        in   1       kill stage contents (branch taken / exception)
//  in_valid     in   1       ID presents a valid instruction
//  in_ready     out  1       stage can accept this cycle
//  fourPC       in   DATA_W  PC+4 of ID instruction
//  readData1    in   DATA_W  rs operand
//  readData2    in   DATA_W  rt operand
//  instruction  in   DATA_W  raw instruction word
//  inst_name    in   NAME_W  decoded instruction code
//  register_d   in   REG_W   destination register
//  out_valid    out  1       EX holds a valid instruction
//  out_ready    in   1       EX consumes the current entry this cycle
//  out_fourPC, out_readData1, out_readData2, out_instruction  out DATA_W  registered copies
//  out_inst_name   out  NAME_W  registered inst_name (0 when bubble)
//  out_register_d  out  REG_W   registered register_d (0 when bubble)
//  stall_cnt    out  CNT_W   saturating count of cycles with out_valid && !out_ready
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, all out_* data=0, stall_cnt=0, skid empty; in_ready=1.
//  - Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready.
//  - Latency: accepted instruction appears on out_* exactly 1 cycle later (no skid in use).
//  - Main entry loads when empty or being consumed; otherwise holds all out_* stable (stall).
//  - out_* never change while out_valid && !out_ready (except flush / reset).
//  - Bubble: whenever out_valid=0, out_inst_name=0 and out_register_d=0 (no false writeback/forwarding);
//    other data fields don't-care but driven 0 after reset/flush.
//  - flush: priority over every other event. Next cycle out_valid=0, skid emptied, bubble fields 0;
//    an in_valid in the flush cycle is dropped (not accepted, no later appearance).
//  - Simultaneous in/out transfer on full main entry: new data replaces old, out_valid stays 1.
//  - stall_cnt: +1 per cycle with out_valid && !out_ready && !flush; saturates at 2^CNT_W-1;
//    cleared only by reset (not by flush).
// CONFIGURATION
//  ID_EX_SKID_EN defined: 2-entry skid buffer (main + skid). in_ready is a flop = !skid_valid.
//   Input taken while main full and not draining -> goes to skid; on next drain skid moves to main
//   (FIFO order kept). Full-throughput, no combinational path out_ready->in_ready.
//  ID_EX_SKID_EN undefined: single entry; in_ready = !out_valid || out_ready (combinational).
//   Skid logic absent; all other behaviour identical.
// TESTING
//  1 Reset: rst=0 mid-stream with out_valid=1 -> immediately out_valid=0, out_*=0, stall_cnt=0, in_ready=1.
//  2 Streaming: in_valid=1 every cycle, out_ready=1, fourPC=4,8,12.. -> out_fourPC 4,8,12.. 1 cycle later, no gaps.
//  3 Stall: load inst_name=8'h23 then out_ready=0 for 5 cycles -> out_* held, stall_cnt=5; without skid
//    in_ready=0 during stall; with ID_EX_SKID_EN exactly one more instruction accepted, then in_ready=0,
//    and both emerge in order after out_ready=1.
//  4 Flush: flush=1 with in_valid=1, register_d=5'd31 -> next cycle out_valid=0, out_register_d=0,
//    out_inst_name=0; dropped instruction never appears; stall_cnt unchanged.
//  5 Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.
//  6 Random valid/ready/flush vs scoreboard, both macro settings -> no loss/duplication/reorder except flushed.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush and an EX back-pressure counter.
// Define ID_EX_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NAME_W = 8,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] fourPC,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] instruction,
  input  logic [NAME_W-1:0] inst_name,
  input  logic [REG_W-1:0]  register_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_fourPC,
  output logic [DATA_W-1:0] out_readData1,
  output logic [DATA_W-1:0] out_readData2,
  output logic [DATA_W-1:0] out_instruction,
  output logic [NAME_W-1:0] out_inst_name,
  output logic [REG_W-1:0]  out_register_d,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAY_W = 4 * DATA_W + NAME_W + REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic [PAY_W-1:0] main_pay_nxt;
  logic             main_vld_nxt;
  logic             drain_c;
  logic             accept_c;

  assign in_pay = {fourPC, readData1, readData2, instruction, inst_name, register_d};
  assign {out_fourPC, out_readData1, out_readData2, out_instruction,
          out_inst_name, out_register_d} = main_pay;

  // Main entry may take new data when empty or being consumed this cycle
  assign drain_c  = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

`ifdef ID_EX_SKID_EN
  logic [PAY_W-1:0] skid_pay;
  logic [PAY_W-1:0] skid_pay_nxt;
  logic             skid_vld;
  logic             skid_vld_nxt;

  // in_ready is low exactly while the skid holds an entry, so skid and input never compete
  always_comb begin
    main_pay_nxt = main_pay;
    main_vld_nxt = out_valid;
    skid_pay_nxt = skid_pay;
    skid_vld_nxt = skid_vld;
    if (flush) begin
      main_pay_nxt = '0;
      main_vld_nxt = 1'b0;
      skid_pay_nxt = '0;
      skid_vld_nxt = 1'b0;
    end else if (drain_c) begin
      if (skid_vld) begin
        main_pay_nxt = skid_pay;
        main_vld_nxt = 1'b1;
        skid_pay_nxt = '0;
        skid_vld_nxt = 1'b0;
      end else begin
        main_pay_nxt = accept_c ? in_pay : '0;
        main_vld_nxt = accept_c;
      end
    end else if (accept_c) begin
      skid_pay_nxt = in_pay;
      skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_pay <= '0;
      skid_vld <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      skid_pay <= skid_pay_nxt;
      skid_vld <= skid_vld_nxt;
      in_ready <= !skid_vld_nxt;
    end
  end
`else
  assign in_ready = drain_c;

  // Single entry: a drained slot with no new input becomes a zeroed bubble
  always_comb begin
    main_pay_nxt = main_pay;
    main_vld_nxt = out_valid;
    if (flush) begin
      main_pay_nxt = '0;
      main_vld_nxt = 1'b0;
    end else if (drain_c) begin
      main_pay_nxt = accept_c ? in_pay : '0;
      main_vld_nxt = accept_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pay  <= '0;
      out_valid <= 1'b0;
    end else begin
      main_pay  <= main_pay_nxt;
      out_valid <= main_vld_nxt;
    end
  end

  // Saturating count of EX back-pressure cycles; flush does not clear it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
